axi_lite_sram_slave: RTL and testbench

AXI4-Lite responder that terminates the core's single-master data/instruction bus in simulation and FPGA bring-up. It provides a word-organised SRAM behind independent read and write channels, byte-lane write strobes, programmable response latency and DECERR for out-of-window addresses. It sits on the far side of `axi_lite_arbitrator` and is driven by the arbitrator's `ar*/r*/aw*/w*/b*` signals.

---
 rtl/axi_lite_sram_slave.sv | 217 +++++++++++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave
//   AXI4-Lite responder backed by a word-organised SRAM. Independent read and
//   write channels, one outstanding transaction each, byte-lane write strobes,
//   programmable response latency and DECERR for addresses outside the window.
//
// Parameters
//   BASE_ADDR    first byte address of the memory window
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   READ_LAT     cycles from AR handshake to rvalid_o   (1..15)
//   WRITE_LAT    cycles from the later AW/W handshake to bvalid_o (1..15)
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   araddr_i/arvalid_i/arready_o read address channel
//   rdata_o/rresp_o/rvalid_o/rready_i  read data channel (00 OKAY, 11 DECERR)
//   awaddr_i/awvalid_i/awready_o write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o  write data channel
//   bresp_o/bvalid_o/bready_i    write response channel (00 OKAY, 11 DECERR)
module axi_lite_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          READ_LAT    = 1,
  parameter int          WRITE_LAT   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] araddr_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  input  logic [31:0] awaddr_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;
  // The handshake cycle counts as the first latency cycle, so the WAIT state
  // only has to cover the remaining LAT-1 cycles (none at all for LAT=1).
  localparam logic [3:0]  RD_LOAD   = 4'(READ_LAT - 1);
  localparam logic [3:0]  WR_LOAD   = 4'(WRITE_LAT - 1);
  localparam logic        RD_FAST   = (READ_LAT == 1);
  localparam logic        WR_FAST   = (WRITE_LAT == 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;

  logic [31:0] r_mem [DEPTH_WORDS];

  // ---------------------------------------------------------------- read side
  rstate_t     r_rstate;
  logic [3:0]  r_rcnt;
  logic [31:0] r_araddr;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rvalid;

  logic [31:0]      w_rd_addr;
  logic [31:0]      w_rd_off;
  logic             w_rd_in;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_rd_sample;

  // In R_IDLE the sample (LAT=1) uses the address on the bus this cycle.
  assign w_rd_addr   = (r_rstate == R_IDLE) ? araddr_i : r_araddr;
  assign w_rd_off    = w_rd_addr - BASE_ADDR;
  assign w_rd_in     = (w_rd_addr >= BASE_ADDR) && ({1'b0, w_rd_off} < WIN_BYTES);
  assign w_rd_idx    = w_rd_off[IDX_W+1:2];
  assign w_rd_sample = (r_rstate == R_IDLE && arvalid_i && RD_FAST) ||
                       (r_rstate == R_WAIT && r_rcnt == 4'd1);

  assign arready_o = (r_rstate == R_IDLE) && !rst_i;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign rresp_o   = r_rresp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate <= R_IDLE;
      r_rcnt   <= '0;
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      // Sampling shares the edge with a write commit, so a colliding read
      // returns the pre-write word.
      if (w_rd_sample) begin
        r_rdata  <= w_rd_in ? r_mem[w_rd_idx] : 32'd0;
        r_rresp  <= w_rd_in ? 2'b00 : 2'b11;
        r_rvalid <= 1'b1;
      end
      case (r_rstate)
        R_IDLE: if (arvalid_i) begin
          r_araddr <= araddr_i;
          r_rcnt   <= RD_LOAD;
          r_rstate <= RD_FAST ? R_RESP : R_WAIT;
        end
        R_WAIT: begin
          if (r_rcnt == 4'd1) r_rstate <= R_RESP;
          else                r_rcnt   <= r_rcnt - 4'd1;
        end
        R_RESP: if (rready_i) begin
          r_rvalid <= 1'b0;
          r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write side
  wstate_t     r_wstate;
  logic [3:0]  r_wcnt;
  logic        r_aw_held;
  logic        r_w_held;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp;
  logic        r_bvalid;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_both;
  logic             w_wr_fire;
  logic [31:0]      w_wr_addr;
  logic [31:0]      w_wr_data;
  logic [3:0]       w_wr_strb;
  logic [31:0]      w_wr_off;
  logic             w_wr_in;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_aw_hs = (r_wstate == W_IDLE) && !r_aw_held && awvalid_i;
  assign w_w_hs  = (r_wstate == W_IDLE) && !r_w_held  && wvalid_i;
  assign w_both  = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_fire = (w_both && WR_FAST) || (r_wstate == W_WAIT && r_wcnt == 4'd1);

  // With WRITE_LAT=1 the commit happens on the completing handshake edge, so
  // whichever half arrives this cycle is taken straight from the bus.
  assign w_wr_addr = w_aw_hs ? awaddr_i : r_awaddr;
  assign w_wr_data = w_w_hs  ? wdata_i  : r_wdata;
  assign w_wr_strb = w_w_hs  ? wstrb_i  : r_wstrb;
  assign w_wr_off  = w_wr_addr - BASE_ADDR;
  assign w_wr_in   = (w_wr_addr >= BASE_ADDR) && ({1'b0, w_wr_off} < WIN_BYTES);
  assign w_wr_idx  = w_wr_off[IDX_W+1:2];

  assign awready_o = (r_wstate == W_IDLE) && !r_aw_held && !rst_i;
  assign wready_o  = (r_wstate == W_IDLE) && !r_w_held  && !rst_i;
  assign bvalid_o  = r_bvalid;
  assign bresp_o   = r_bresp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate  <= W_IDLE;
      r_wcnt    <= '0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= '0;
      r_bvalid  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awaddr  <= awaddr_i;
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= wdata_i;
        r_wstrb  <= wstrb_i;
        r_w_held <= 1'b1;
      end
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_in ? 2'b00 : 2'b11;
      end
      case (r_wstate)
        W_IDLE: if (w_both) begin
          r_wcnt   <= WR_LOAD;
          r_wstate <= WR_FAST ? W_RESP : W_WAIT;
        end
        W_WAIT: begin
          if (r_wcnt == 4'd1) r_wstate <= W_RESP;
          else                r_wcnt   <= r_wcnt - 4'd1;
        end
        W_RESP: if (bready_i) begin
          r_bvalid  <= 1'b0;
          r_aw_held <= 1'b0;
          r_w_held  <= 1'b0;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Memory array has no reset; out-of-window writes are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr_fire && w_wr_in) begin
      for (int k = 0; k < 4; k++) begin
        if (w_wr_strb[k]) r_mem[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Scoreboard bench: tasks push expected responses, a negedge monitor pops and
// compares them. DUT 0 runs at READ_LAT=WRITE_LAT=1, DUT 1 at READ_LAT=4,
// WRITE_LAT=3 for latency, backpressure and mid-transaction reset cases.
module tb_axi_lite_sram_slave;

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic [1:0]  resp;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr [2];
  logic [31:0] rdata  [2];
  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic [1:0]  rresp  [2];
  logic [1:0]  bresp  [2];
  logic [1:0]  arvalid, arready, rvalid, rready;
  logic [1:0]  awvalid, awready, wvalid, wready, bvalid, bready;

  exp_t rq[$];
  exp_t bq[$];
  int   n_tot  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  logic [1:0] rv_prev = 2'b00;
  logic [1:0] bv_prev = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_sram_slave #(.READ_LAT(1), .WRITE_LAT(1)) u_d0 (
    .clk_i(clk), .rst_i(rst),
    .araddr_i(araddr[0]), .arvalid_i(arvalid[0]), .arready_o(arready[0]),
    .rdata_o(rdata[0]), .rresp_o(rresp[0]), .rvalid_o(rvalid[0]), .rready_i(rready[0]),
    .awaddr_i(awaddr[0]), .awvalid_i(awvalid[0]), .awready_o(awready[0]),
    .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .wvalid_i(wvalid[0]), .wready_o(wready[0]),
    .bresp_o(bresp[0]), .bvalid_o(bvalid[0]), .bready_i(bready[0])
  );

  axi_lite_sram_slave #(.READ_LAT(4), .WRITE_LAT(3)) u_d1 (
    .clk_i(clk), .rst_i(rst),
    .araddr_i(araddr[1]), .arvalid_i(arvalid[1]), .arready_o(arready[1]),
    .rdata_o(rdata[1]), .rresp_o(rresp[1]), .rvalid_o(rvalid[1]), .rready_i(rready[1]),
    .awaddr_i(awaddr[1]), .awvalid_i(awvalid[1]), .awready_o(awready[1]),
    .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .wvalid_i(wvalid[1]), .wready_o(wready[1]),
    .bresp_o(bresp[1]), .bvalid_o(bvalid[1]), .bready_i(bready[1])
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic void fail_now(string nm);
    n_tot++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endfunction

  // Monitor: compares every presented response against the queue head.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rvalid[d]) begin
        if (rq.size() == 0 || rq[0].dut != d) chk("r_unexpected", 32'(rvalid[d]), 32'd0);
        else begin
          if (!rv_prev[d]) chk("r_latency", cyc, rq[0].due);
          chk("r_data", rdata[d], rq[0].data);
          chk("r_resp", 32'(rresp[d]), 32'(rq[0].resp));
          if (rready[d]) void'(rq.pop_front());
        end
      end
      if (bvalid[d]) begin
        if (bq.size() == 0 || bq[0].dut != d) chk("b_unexpected", 32'(bvalid[d]), 32'd0);
        else begin
          if (!bv_prev[d]) chk("b_latency", cyc, bq[0].due);
          chk("b_resp", 32'(bresp[d]), 32'(bq[0].resp));
          if (bready[d]) void'(bq.pop_front());
        end
      end
    end
    rv_prev = rvalid;
    bv_prev = bvalid;
  end

  task automatic rd(int d, logic [31:0] a, logic [31:0] ed, logic [1:0] er, bit push);
    bit   got = 1'b0;
    exp_t e;
    araddr[d]  = a;
    arvalid[d] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (arready[d]) begin got = 1'b1; break; end
    end
    if (!got) fail_now("ar_handshake");
    else if (push) begin
      e.dut = d; e.data = ed; e.resp = er; e.due = cyc + (d == 1 ? 4 : 1);
      rq.push_back(e);
    end
    @(posedge clk); #1 arvalid[d] = 1'b0;
  endtask

  task automatic wr(int d, logic [31:0] a, logic [31:0] dt, logic [3:0] s,
                    int aw_dly, int w_dly, logic [1:0] er, bit push);
    int   t_aw = -1;
    int   t_w  = -1;
    exp_t e;
    fork
      begin
        repeat (aw_dly) begin @(posedge clk); #1; end
        awaddr[d]  = a;
        awvalid[d] = 1'b1;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (awready[d]) begin t_aw = cyc; break; end
        end
        @(posedge clk); #1 awvalid[d] = 1'b0;
      end
      begin
        repeat (w_dly) begin @(posedge clk); #1; end
        wdata[d]  = dt;
        wstrb[d]  = s;
        wvalid[d] = 1'b1;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (wready[d]) begin t_w = cyc; break; end
        end
        @(posedge clk); #1 wvalid[d] = 1'b0;
      end
    join
    if (t_aw < 0 || t_w < 0) fail_now("aw_w_handshake");
    else if (push) begin
      e.dut = d; e.data = 32'd0; e.resp = er;
      e.due = ((t_aw > t_w) ? t_aw : t_w) + (d == 1 ? 3 : 1);
      bq.push_back(e);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (rq.size() == 0 && bq.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("response_drain");
      rq.delete();
      bq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_ready(string nm, logic exp);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_arready"}, 32'(arready[d]), 32'(exp));
      chk({nm, "_awready"}, 32'(awready[d]), 32'(exp));
      chk({nm, "_wready"},  32'(wready[d]),  32'(exp));
    end
  endtask

  initial begin
    arvalid = '0; awvalid = '0; wvalid = '0; rready = 2'b11; bready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      araddr[d] = '0; awaddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk_ready("rst", 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
      chk("rst_bvalid", 32'(bvalid[d]), 32'd0);
      chk("rst_rdata",  rdata[d], 32'd0);
      chk("rst_rresp",  32'(rresp[d]), 32'd0);
      chk("rst_bresp",  32'(bresp[d]), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_ready("post_rst", 1'b1);
    @(posedge clk); #1;

    // Write / readback
    wr(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 1); drain();
    rd(0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1);            drain();

    // Byte strobes
    wr(0, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, 2'b00, 1); drain();
    wr(0, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 0, 0, 2'b00, 1); drain();
    rd(0, 32'h8000_0020, 32'h11BB_33DD, 2'b00, 1);            drain();

    // Channel ordering: W first, AW first, same cycle
    wr(0, 32'h8000_0030, 32'h0102_0304, 4'hF, 3, 0, 2'b00, 1); drain();
    rd(0, 32'h8000_0030, 32'h0102_0304, 2'b00, 1);            drain();
    wr(0, 32'h8000_0034, 32'h0506_0708, 4'hF, 0, 3, 2'b00, 1); drain();
    rd(0, 32'h8000_0034, 32'h0506_0708, 2'b00, 1);            drain();
    wr(0, 32'h8000_0038, 32'h0A0B_0C0D, 4'hF, 0, 0, 2'b00, 1); drain();
    rd(0, 32'h8000_0038, 32'h0A0B_0C0D, 2'b00, 1);            drain();

    // Zero strobe and unaligned address
    wr(0, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 0, 2'b00, 1); drain();
    rd(0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1);            drain();
    rd(0, 32'h8000_0013, 32'hDEAD_BEEF, 2'b00, 1);            drain();

    // Decode errors, window edges untouched
    wr(0, 32'h8000_0000, 32'h1234_5678, 4'hF, 0, 0, 2'b00, 1); drain();
    wr(0, 32'h8000_3FFC, 32'h9ABC_DEF0, 4'hF, 0, 0, 2'b00, 1); drain();
    rd(0, 32'h7FFF_FFFC, 32'h0000_0000, 2'b11, 1);            drain();
    wr(0, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b11, 1); drain();
    rd(0, 32'h8000_4000, 32'h0000_0000, 2'b11, 1);            drain();
    rd(0, 32'h8000_0000, 32'h1234_5678, 2'b00, 1);            drain();
    rd(0, 32'h8000_3FFC, 32'h9ABC_DEF0, 2'b00, 1);            drain();

    // Longer latencies on DUT 1
    wr(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 1); drain();
    wr(1, 32'h8000_0044, 32'h7777_8888, 4'hF, 2, 0, 2'b00, 1); drain();
    rd(1, 32'h8000_0044, 32'h7777_8888, 2'b00, 1);            drain();

    // Backpressure: rready low for 5 cycles after rvalid rises
    rready[1] = 1'b0;
    rd(1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rvalid[1]) begin seen = 1'b1; break; end
        chk("bp_arready_wait", 32'(arready[1]), 32'd0);
      end
      if (!seen) fail_now("bp_rvalid");
    end
    repeat (4) begin
      chk("bp_arready_hold", 32'(arready[1]), 32'd0);
      @(negedge clk);
    end
    chk("bp_arready_hold", 32'(arready[1]), 32'd0);
    @(posedge clk); #1 rready[1] = 1'b1;
    @(negedge clk);
    chk("bp_arready_hs", 32'(arready[1]), 32'd0);
    @(negedge clk);
    chk("bp_arready_after", 32'(arready[1]), 32'd1);
    drain();

    // Reset during W_WAIT
    wr(1, 32'h8000_0040, 32'h5555_5555, 4'hF, 0, 0, 2'b00, 1); drain();
    wr(1, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, 0, 0, 2'b00, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_ready("in_rst", 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_ready("wrst_release", 1'b1);
    repeat (8) begin
      @(negedge clk);
      chk("wrst_no_bvalid", 32'(bvalid[1]), 32'd0);
    end
    @(posedge clk); #1;
    rd(1, 32'h8000_0040, 32'h5555_5555, 2'b00, 1); drain();

    // Reset during R_WAIT
    rd(1, 32'h8000_0040, 32'h0000_0000, 2'b00, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_ready("rrst_release", 1'b1);
    repeat (8) begin
      @(negedge clk);
      chk("rrst_no_rvalid", 32'(rvalid[1]), 32'd0);
    end
    @(posedge clk); #1;
    rd(1, 32'h8000_0040, 32'h5555_5555, 2'b00, 1); drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
